// File: rtl/mini_cpu_pkg.sv
// Shared opcode and FSM state encodings for the mini CPU core.
package mini_cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_LDI  = 3'd5,
    OP_MOV  = 3'd6,
    OP_HALT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    HALT = 2'd3
  } state_e;

endpackage

// File: rtl/mini_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear of every entry.
module mini_regfile #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned REG_CNT = 4,
  localparam int unsigned AW     = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic [AW-1:0]     i_raddr2,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_mem [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_CNT; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/mini_cpu_core.sv
// Multi-cycle mini CPU core: IDLE -> EXEC -> WB per instruction, HALT is terminal.
// Optional status flags are built only when MINI_CPU_FLAGS_EN is defined.
module mini_cpu_core
  import mini_cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned REG_CNT = 4,
  localparam int unsigned AW     = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [AW-1:0]     rd,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] alu_result,
  output logic              result_valid,
  output logic              reg_write,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              halted
);

  state_e            r_state, w_next;
  op_e               r_op;
  logic [AW-1:0]     r_rd, r_rs1, r_rs2;
  logic [DATA_W-1:0] r_imm, r_result;
  logic [DATA_W-1:0] w_a, w_b, w_alu;
  logic              w_exec_wr;

  mini_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (reg_write),
    .i_waddr  (r_rd),
    .i_wdata  (r_result),
    .i_raddr1 (r_rs1),
    .o_rdata1 (w_a),
    .i_raddr2 (r_rs2),
    .o_rdata2 (w_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    instr_ready  = 1'b0;
    result_valid = 1'b0;
    reg_write    = 1'b0;
    halted       = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = EXEC;
      end
      EXEC: w_next = (r_op == OP_HALT) ? HALT : WB;
      WB: begin
        result_valid = 1'b1;
        reg_write    = 1'b1;
        w_next       = IDLE;
      end
      HALT: halted = 1'b1;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= OP_ADD;
      r_rd  <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_imm <= '0;
    end else if (r_state == IDLE && instr_valid) begin
      r_op  <= op_e'(opcode);
      r_rd  <= rd;
      r_rs1 <= rs1;
      r_rs2 <= rs2;
      r_imm <= imm;
    end
  end

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_LDI:  w_alu = r_imm;
      OP_MOV:  w_alu = w_a;
      default: w_alu = r_result;
    endcase
  end

  assign w_exec_wr = (r_state == EXEC) && (r_op != OP_HALT);

  // Result is captured at the end of EXEC so it is already stable while
  // result_valid pulses in WB; it doubles as the held alu_result output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_result <= '0;
    else if (w_exec_wr) r_result <= w_alu;
  end

  assign alu_result = r_result;

`ifdef MINI_CPU_FLAGS_EN
  logic r_zero, r_carry, w_carry;

  // ADD carry-out detected as wrap-around of the truncated sum.
  always_comb begin
    w_carry = 1'b0;
    if (r_op == OP_ADD)      w_carry = (w_alu < w_a);
    else if (r_op == OP_SUB) w_carry = (w_a < w_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_exec_wr) begin
      r_zero  <= (w_alu == '0);
      r_carry <= w_carry;
    end
  end

  assign flag_zero  = r_zero;
  assign flag_carry = r_carry;
`else
  assign flag_zero  = 1'b0;
  assign flag_carry = 1'b0;
`endif

endmodule

// File: tb/tb_mini_cpu_core.sv
// Directed self-checking bench for mini_cpu_core; flag expectations follow
// whether MINI_CPU_FLAGS_EN is defined for the build.
module tb_mini_cpu_core;
  import mini_cpu_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned RC = 4;
`ifdef MINI_CPU_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    opcode;
  logic [1:0]    rd, rs1, rs2;
  logic [DW-1:0] imm;
  logic [DW-1:0] alu_result;
  logic          result_valid, reg_write, flag_zero, flag_carry, halted;

  int total = 0;
  int bad   = 0;

  mini_cpu_core #(.DATA_W(DW), .REG_CNT(RC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode       (opcode),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .imm          (imm),
    .alu_result   (alu_result),
    .result_valid (result_valid),
    .reg_write    (reg_write),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the core in IDLE; returns at the negedge of the cycle after WB.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [1:0] d,
                       input logic [1:0] a, input logic [1:0] b, input logic [7:0] im,
                       input logic [7:0] er, input logic ez, input logic ec);
    opcode = op; rd = d; rs1 = a; rs2 = b; imm = im; instr_valid = 1'b1;
    chk({tag, ".ready"}, instr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    opcode = ~op; rd = ~d; rs1 = ~a; rs2 = ~b; imm = im ^ 8'h5A;
    chk({tag, ".exec_rv"}, result_valid, 0);
    @(negedge clk);
    chk({tag, ".wb_rv"}, result_valid, 1);
    chk({tag, ".wb_rw"}, reg_write, 1);
    chk({tag, ".result"}, alu_result, er);
    chk({tag, ".zero"}, flag_zero, FL ? ez : 1'b0);
    chk({tag, ".carry"}, flag_carry, FL ? ec : 1'b0);
    @(negedge clk);
    chk({tag, ".post_rv"}, result_valid, 0);
    chk({tag, ".post_ready"}, instr_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst.ready", instr_ready, 1);
    chk("rst.result", alu_result, 0);
    chk("rst.rv", result_valid, 0);
    chk("rst.rw", reg_write, 0);
    chk("rst.halted", halted, 0);
    chk("rst.zero", flag_zero, 0);
    chk("rst.carry", flag_carry, 0);
    do_op("mov_r3_rst", OP_MOV, 2'd3, 2'd3, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);

    do_op("ldi_r1_05", OP_LDI, 2'd1, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 1'b0);
    do_op("ldi_r2_03", OP_LDI, 2'd2, 2'd0, 2'd0, 8'h03, 8'h03, 1'b0, 1'b0);
    do_op("add_r3", OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, 8'h08, 1'b0, 1'b0);
    do_op("sub_r3_self", OP_SUB, 2'd3, 2'd3, 2'd3, 8'h00, 8'h00, 1'b1, 1'b0);

    do_op("ldi_r1_ff", OP_LDI, 2'd1, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    do_op("ldi_r2_01", OP_LDI, 2'd2, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0);
    do_op("add_wrap", OP_ADD, 2'd0, 2'd1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b1);
    do_op("sub_12", OP_SUB, 2'd3, 2'd1, 2'd2, 8'h00, 8'hFE, 1'b0, 1'b0);
    do_op("sub_21", OP_SUB, 2'd3, 2'd2, 2'd1, 8'h00, 8'h02, 1'b0, 1'b1);
    do_op("and", OP_AND, 2'd3, 2'd1, 2'd2, 8'h00, 8'h01, 1'b0, 1'b0);
    do_op("or", OP_OR, 2'd3, 2'd1, 2'd2, 8'h00, 8'hFF, 1'b0, 1'b0);
    do_op("xor", OP_XOR, 2'd3, 2'd1, 2'd2, 8'h00, 8'hFE, 1'b0, 1'b0);
    do_op("mov_r0", OP_MOV, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    do_op("mov_r3", OP_MOV, 2'd3, 2'd3, 2'd0, 8'h00, 8'hFE, 1'b0, 1'b0);

    // instr_valid held high: handshake every third cycle, EXEC/WB inputs ignored
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      opcode = OP_LDI; rd = 2'd2; imm = 8'h10 + 8'(k);
      chk("cont.ready", instr_ready, 1);
      @(posedge clk);
      @(negedge clk);
      opcode = OP_HALT; rd = 2'd1; imm = 8'hEE;
      chk("cont.exec_ready", instr_ready, 0);
      chk("cont.exec_rv", result_valid, 0);
      @(negedge clk);
      chk("cont.wb_rv", result_valid, 1);
      chk("cont.result", alu_result, 32'h10 + k);
      opcode = OP_XOR;
      @(negedge clk);
      chk("cont.post_rv", result_valid, 0);
    end
    instr_valid = 1'b0;
    do_op("cont.mov_r2", OP_MOV, 2'd2, 2'd2, 2'd0, 8'h00, 8'h12, 1'b0, 1'b0);
    do_op("cont.mov_r1", OP_MOV, 2'd1, 2'd1, 2'd0, 8'h00, 8'hFF, 1'b0, 1'b0);

    opcode = OP_HALT; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("halt.exec_halted", halted, 0);
    opcode = OP_LDI; rd = 2'd1; imm = 8'h77;
    @(negedge clk);
    chk("halt.halted", halted, 1);
    chk("halt.ready", instr_ready, 0);
    chk("halt.rv", result_valid, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt.hold_halted", halted, 1);
      chk("halt.hold_ready", instr_ready, 0);
      chk("halt.hold_rv", result_valid, 0);
      chk("halt.hold_rw", reg_write, 0);
      chk("halt.hold_result", alu_result, 8'hFF);
    end
    rst_n = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("halt.rst_halted", halted, 0);
    chk("halt.rst_ready", instr_ready, 1);
    chk("halt.rst_result", alu_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("halt.mov_r1", OP_MOV, 2'd1, 2'd1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);

    do_op("abort.ldi_r2_33", OP_LDI, 2'd2, 2'd0, 2'd0, 8'h33, 8'h33, 1'b0, 1'b0);
    opcode = OP_LDI; rd = 2'd2; imm = 8'hAA; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort.wb_rv", result_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("abort.rst_rv", result_valid, 0);
    chk("abort.rst_rw", reg_write, 0);
    chk("abort.rst_result", alu_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort.rel_rv", result_valid, 0);
    @(negedge clk);
    chk("abort.idle_rv", result_valid, 0);
    do_op("abort.mov_r2", OP_MOV, 2'd2, 2'd2, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mini_cpu_core.md
# mini_cpu_core

Parametrised multi-cycle successor to the 4-bit mini CPU datapath. It accepts one instruction per valid/ready handshake and reads two operands from an internal register file. It executes one of eight ALU/load/halt operations, writes the result back, and reports the result and status flags. It sits between an external instruction sequencer (testbench or fetch unit) and any consumer of `alu_result`.

## Interface
- `DATA_W`, 8: datapath and register width in bits (≥2).
- `REG_CNT`, 4: number of registers (power of two, ≥2); `AW = $clog2(REG_CNT)`.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  core can accept an instruction.
- `opcode`  in  3  operation.
- `rd`  in  AW  destination register.
- `rs1`, `rs2`  in  AW  source registers.
- `imm`  in  DATA_W  immediate for LDI.
- `alu_result`  out  DATA_W  last written-back result, held until the next writeback.
- `result_valid`  out  1  one-cycle pulse on writeback.
- `reg_write`  out  1  register-file write enable; high in WB for non-HALT ops.
- `flag_zero`, `flag_carry`  out  1  status flags.
- `halted`  out  1  core stopped by HALT.

## Operation
- FSM states: IDLE, EXEC, WB, HALT.
- IDLE: `instr_ready=1`. On `instr_valid&&instr_ready`, latch `opcode`, `rd`, `rs1`, `rs2` and `imm`, then go to EXEC. With no valid, stay in IDLE.
- EXEC: read `R[rs1]` and `R[rs2]`, compute into the internal result register, then go to WB. HALT goes to the HALT state instead.
- WB: write `R[rd]`, update `alu_result` and the flags, pulse `result_valid` and `reg_write`, then go to IDLE.
- HALT: `halted=1`, `instr_ready=0`. Only `rst_n` exits this state.
- Opcodes:
  - 000 ADD: `rs1+rs2`, carry = bit DATA_W of the sum.
  - 001 SUB: `rs1-rs2`, carry = borrow (`rs1<rs2`, unsigned).
  - 010 AND, 011 OR, 100 XOR: carry cleared.
  - 101 LDI: result = `imm`, carry cleared.
  - 110 MOV: result = `R[rs1]`, carry cleared.
  - 111 HALT: no write, flags unchanged.
- Results wrap modulo 2^DATA_W. `flag_zero` = (result == 0).
- Operands are read in EXEC, after the previous WB has completed, so there are no hazards. `rd == rs1 == rs2` is legal.
- Inputs are ignored outside the IDLE handshake cycle.

## Timing
- Reset values: all registers 0; state IDLE; `alu_result=0`; all flags 0; `result_valid=0`; `reg_write=0`; `halted=0`; `instr_ready=1` (combinational from IDLE).
- Handshake at edge N: EXEC in cycle N+1, WB in cycle N+2 (`result_valid=1`). The register value is visible from edge N+3. `instr_ready` rises again in cycle N+3.
- Throughput: one instruction per 3 cycles.
- HALT accepted at N: `halted=1` from cycle N+2 onward, with no `result_valid`.
- Reset asserted mid-operation (EXEC or WB): the in-flight write is aborted and all state returns immediately to reset values.

## Configuration
- Macro `MINI_CPU_FLAGS_EN`.
- Defined: `flag_zero` and `flag_carry` are registered and updated as above.
- Undefined: no flag registers are built and both flag outputs are tied to 0. All other behaviour is identical.

## Structure
- Package `mini_cpu_pkg`: opcode enum (`OP_ADD`…`OP_HALT`, 3 bits) and state enum (IDLE/EXEC/WB/HALT).
- Sub-module `mini_regfile`, parametrised by `DATA_W` and `REG_CNT`:
  - two asynchronous read ports, one synchronous write port;
  - asynchronous active-low clear.

## Test plan
- Reset, then LDI r1=0x05, LDI r2=0x03, ADD r3=r1+r2: `alu_result=0x08`, zero=0, carry=0. `result_valid` pulses exactly 2 cycles after each handshake.
- LDI r1=0xFF, LDI r2=0x01, ADD r0: result 0x00, zero=1, carry=1 (wrap). SUB r1-r2 = 0xFE, carry=0. SUB r2-r1 = 0x02, carry=1 (borrow).
- Hold `instr_valid=1` continuously: a handshake occurs every 3rd cycle, and opcode changes during EXEC/WB are ignored.
- HALT: `halted=1` and `instr_ready=0` persist through 10 further valid cycles with no register change. Asserting `rst_n=0` clears all state; after reset, MOV r1 returns 0.
- Assert `rst_n=0` during the WB of LDI r2=0xAA: r2 reads 0 after reset and `result_valid` stays 0.
- Build with `MINI_CPU_FLAGS_EN` undefined: repeat scenario 2; the flags stay 0 and results are unchanged.
